// File: rtl/counter_step_decoder_if.sv
// Sample bus from the observed up/down counter into the step decoder.
interface counter_step_decoder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             smp_valid;
  logic [WIDTH-1:0] smp_data;

  modport master (output smp_valid, output smp_data);
  modport slave  (input  smp_valid, input  smp_data);
endinterface

// File: rtl/counter_step_decoder.sv
// Passive monitor for an up/down loadable counter: classifies each sampled step
// as hold/up/down/wrap/jump and tracks direction, lock and saturating statistics.
module counter_step_decoder #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned STAT_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  counter_step_decoder_if.slave  smp,
  input  logic                   clr_stats,
  output logic [1:0]             dir,
  output logic                   locked,
  output logic                   up_pulse,
  output logic                   down_pulse,
  output logic                   wrap_pulse,
  output logic                   jump_pulse,
  output logic [STAT_W-1:0]      up_cnt,
  output logic [STAT_W-1:0]      down_cnt,
  output logic [STAT_W-1:0]      jump_cnt
);

  localparam int unsigned RUN_W = 4;

  typedef enum logic {ACQ, TRACK} state_t;
  typedef enum logic [1:0] {
    DIR_UNK  = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_HOLD = 2'b11
  } dir_t;

  state_t           state;
  dir_t             dir_q;
  dir_t             last_dir;  // direction of the most recent non-hold step
  logic [WIDTH-1:0] prev;
  logic [RUN_W-1:0] run;

  logic             step_c;
  logic             hold_c;
  logic             up_c;
  logic             down_c;
  logic [RUN_W-1:0] run_inc_c;
  logic [RUN_W-1:0] run_up_c;
  logic [RUN_W-1:0] run_down_c;

  // Step classification against the held reference, modulo 2^WIDTH.
  always_comb begin
    step_c     = smp.smp_valid && (state == TRACK);
    hold_c     = (smp.smp_data == prev);
    up_c       = (smp.smp_data == prev + WIDTH'(1));
    down_c     = (smp.smp_data == prev - WIDTH'(1));
    run_inc_c  = (run == RUN_W'(LOCK_CNT)) ? run : run + RUN_W'(1);
    run_up_c   = (last_dir == DIR_UP)   ? run_inc_c : RUN_W'(1);
    run_down_c = (last_dir == DIR_DOWN) ? run_inc_c : RUN_W'(1);
  end

  // Acquisition/tracking FSM with registered direction, lock and pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ACQ;
      dir_q      <= DIR_UNK;
      last_dir   <= DIR_UNK;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      jump_pulse <= 1'b0;
    end else begin
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      jump_pulse <= 1'b0;
      if (smp.smp_valid) begin
        prev <= smp.smp_data;
        case (state)
          ACQ: state <= TRACK;
          TRACK: begin
            if (hold_c) begin
              dir_q <= DIR_HOLD;
            end else if (up_c) begin
              up_pulse   <= 1'b1;
              wrap_pulse <= (prev == '1);
              dir_q      <= DIR_UP;
              last_dir   <= DIR_UP;
              run        <= run_up_c;
              locked     <= (run_up_c == RUN_W'(LOCK_CNT));
            end else if (down_c) begin
              down_pulse <= 1'b1;
              wrap_pulse <= (prev == '0);
              dir_q      <= DIR_DOWN;
              last_dir   <= DIR_DOWN;
              run        <= run_down_c;
              locked     <= (run_down_c == RUN_W'(LOCK_CNT));
            end else begin
              jump_pulse <= 1'b1;
              dir_q      <= DIR_UNK;
              last_dir   <= DIR_UNK;
              run        <= '0;
              locked     <= 1'b0;
            end
          end
          default: state <= ACQ;
        endcase
      end
    end
  end

  assign dir = dir_q;

  // Saturating step statistics; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up_cnt   <= '0;
      down_cnt <= '0;
      jump_cnt <= '0;
    end else if (clr_stats) begin
      up_cnt   <= '0;
      down_cnt <= '0;
      jump_cnt <= '0;
    end else if (step_c) begin
      if (up_c && (up_cnt != '1))
        up_cnt <= up_cnt + STAT_W'(1);
      if (down_c && (down_cnt != '1))
        down_cnt <= down_cnt + STAT_W'(1);
      if (!hold_c && !up_c && !down_c && (jump_cnt != '1))
        jump_cnt <= jump_cnt + STAT_W'(1);
    end
  end

endmodule
